// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, FSM encoding and requester id width.
package alu_pkg;

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

  localparam int ID_W = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; bit 3 of the opcode is a don't-care except for the shifts.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluc,
  output logic [WIDTH-1:0] s,
  output logic             z
);

  logic signed [WIDTH-1:0] b_sgn;

  assign b_sgn = b;

  // Shift count is the full a operand: counts >= WIDTH flush the result.
  always_comb begin
    s = '0;
    casez (aluc)
      4'b?000: s = a + b;
      4'b?100: s = a - b;
      4'b?001: s = a & b;
      4'b?101: s = a | b;
      4'b?010: s = a ^ b;
      4'b?110: s = b << 16;
      ALUC_SLL: s = b << a;
      ALUC_SRL: s = b >> a;
      ALUC_SRA: s = $unsigned(b_sgn >>> a);
      default: s = '0;
    endcase
  end

  assign z = (s == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; one op in flight at a time.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_aluc,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_aluc,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_s,
  output logic             rsp_z
);

  state_t            state, state_nx;
  logic [ID_W-1:0]   last;
  logic [ID_W-1:0]   gnt;
  logic              hs;
  logic [ID_W-1:0]   owner_p0;
  logic [3:0]        aluc_p0;
  logic [WIDTH-1:0]  a_p0;
  logic [WIDTH-1:0]  b_p0;
  logic [WIDTH-1:0]  alu_s;
  logic              alu_z;
  logic              owner_rsp_ready;

  assign owner_rsp_ready = (owner_p0 == ID_W'(1)) ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_nx   = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    hs         = 1'b0;
    // On a tie the requester that did not win last time gets the grant.
    gnt = (req0_valid && req1_valid) ? ~last : ID_W'(req1_valid);
    case (state)
      IDLE: begin
        req0_ready = req0_valid && (gnt == ID_W'(0));
        req1_ready = req1_valid && (gnt == ID_W'(1));
        hs         = req0_valid || req1_valid;
        if (hs) state_nx = EXEC;
      end
      EXEC:    state_nx = RESP;
      RESP:    if (owner_rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign rsp0_valid = (state == RESP) && (owner_p0 == ID_W'(0));
  assign rsp1_valid = (state == RESP) && (owner_p0 == ID_W'(1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      last  <= ID_W'(1);
    end else begin
      state <= state_nx;
      if (hs) last <= gnt;
    end
  end

  // p0: operands captured at the request handshake
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      owner_p0 <= '0;
      aluc_p0  <= '0;
      a_p0     <= '0;
      b_p0     <= '0;
    end else if (hs) begin
      owner_p0 <= gnt;
      aluc_p0  <= (gnt == ID_W'(1)) ? req1_aluc : req0_aluc;
      a_p0     <= (gnt == ID_W'(1)) ? req1_a    : req0_a;
      b_p0     <= (gnt == ID_W'(1)) ? req1_b    : req0_b;
    end
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .a    (a_p0),
    .b    (b_p0),
    .aluc (aluc_p0),
    .s    (alu_s),
    .z    (alu_z)
  );

  // p1: result registered on the EXEC->RESP edge and held through RESP
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rsp_s <= '0;
      rsp_z <= 1'b0;
    end else if (state == EXEC) begin
      rsp_s <= alu_s;
      rsp_z <= alu_z;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic vs a transaction model.
module tb_alu_arbiter;

  logic        clock = 1'b0;
  logic        resetn;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_aluc, req1_aluc;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp_s;
  logic        rsp_z;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int grant_cyc = 0;
  int last_m = 1;

  bit          pend[2];
  logic [3:0]  opc[2];
  logic [31:0] opa[2];
  logic [31:0] opb[2];

  alu_arbiter #(.WIDTH(32)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_aluc  (req0_aluc),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_aluc  (req1_aluc),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_s      (rsp_s),
    .rsp_z      (rsp_z)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = 32'h0;
    if (c == 4'b1011) r = 32'h0;
    else if (c == 4'b0011) r = (a >= 32) ? 32'h0 : (b << a[4:0]);
    else if (c == 4'b0111) r = (a >= 32) ? 32'h0 : (b >> a[4:0]);
    else if (c == 4'b1111) begin
      if (a >= 32) r = {32{b[31]}};
      else r = b[31] ? ~((~b) >> a[4:0]) : (b >> a[4:0]);
    end else begin
      case (c[2:0])
        3'd0: r = a + b;
        3'd4: r = a - b;
        3'd1: r = a & b;
        3'd5: r = a | b;
        3'd2: r = a ^ b;
        3'd6: r = {b[15:0], 16'h0000};
        default: r = 32'h0;
      endcase
    end
    return r;
  endfunction

  task automatic drive_reqs();
    req0_valid = pend[0]; req0_aluc = opc[0]; req0_a = opa[0]; req0_b = opb[0];
    req1_valid = pend[1]; req1_aluc = opc[1]; req1_a = opa[1]; req1_b = opb[1];
  endtask

  task automatic set_op(input int id, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    pend[id] = 1'b1; opc[id] = c; opa[id] = a; opb[id] = b;
  endtask

  // Entered and left at one time unit after a rising edge, DUT in IDLE, at least one request pending.
  task automatic serve_one(input int stall);
    int g;
    logic [31:0] exp_s;
    drive_reqs();
    g = (pend[0] && pend[1]) ? (last_m == 1 ? 0 : 1) : (pend[0] ? 0 : 1);
    #1;
    chk("req0_ready_idle", req0_ready, g == 0);
    chk("req1_ready_idle", req1_ready, g == 1);
    grant_cyc = cyc;
    exp_s = alu_ref(opc[g], opa[g], opb[g]);
    last_m = g;
    @(posedge clock); #1;
    pend[g] = 1'b0;
    drive_reqs();
    rsp0_ready = 1'($urandom);
    rsp1_ready = 1'($urandom);
    #1;
    chk("req0_ready_exec", req0_ready, 0);
    chk("req1_ready_exec", req1_ready, 0);
    chk("rsp0_valid_exec", rsp0_valid, 0);
    chk("rsp1_valid_exec", rsp1_valid, 0);
    @(posedge clock); #1;
    for (int k = 0; k <= stall; k++) begin
      if (g == 0) begin
        rsp0_ready = (k == stall);
        rsp1_ready = 1'($urandom);
      end else begin
        rsp1_ready = (k == stall);
        rsp0_ready = 1'($urandom);
      end
      #1;
      chk("rsp0_valid_resp", rsp0_valid, g == 0);
      chk("rsp1_valid_resp", rsp1_valid, g == 1);
      chk("rsp_s", rsp_s, exp_s);
      chk("rsp_z", rsp_z, exp_s == 0);
      chk("req0_ready_resp", req0_ready, 0);
      chk("req1_ready_resp", req1_ready, 0);
      @(posedge clock); #1;
    end
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    @(posedge clock); #1;
    resetn = 1'b1;
    last_m = 1;
  endtask

  initial begin
    int gc0;
    resetn = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    opc[0] = '0; opc[1] = '0; opa[0] = '0; opa[1] = '0; opb[0] = '0; opb[1] = '0;
    drive_reqs();
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #2;
    chk("reset_rsp_s", rsp_s, 0);
    chk("reset_rsp_z", rsp_z, 0);
    chk("reset_rsp0_valid", rsp0_valid, 0);
    chk("reset_rsp1_valid", rsp1_valid, 0);
    chk("reset_req0_ready", req0_ready, 0);
    chk("reset_req1_ready", req1_ready, 0);
    @(posedge clock); @(posedge clock); #1;
    resetn = 1'b1;
    last_m = 1;

    set_op(0, 4'b0000, 32'd5, 32'd7);
    serve_one(0);
    set_op(1, 4'b0100, 32'd9, 32'd9);
    serve_one(1);

    do_reset();
    set_op(0, 4'b0000, 32'd1, 32'd1);
    set_op(1, 4'b0101, 32'h0000_00F0, 32'h0000_000F);
    serve_one(0);
    gc0 = grant_cyc;
    serve_one(0);
    chk("tie_grant_spacing", grant_cyc - gc0, 3);

    set_op(0, 4'b1111, 32'd4, 32'hF000_0000);
    set_op(1, 4'b0010, 32'h55, 32'hAA);
    serve_one(3);
    serve_one(0);

    set_op(0, 4'b1011, 32'd3, 32'd3);
    serve_one(0);
    set_op(0, 4'b0011, 32'd4, 32'd1);
    serve_one(0);

    set_op(0, 4'b0010, 32'h1234_5678, 32'h0F0F_0F0F);
    drive_reqs();
    @(posedge clock); #1;
    pend[0] = 1'b0;
    drive_reqs();
    resetn = 1'b0;
    #1;
    chk("rst_exec_rsp_s", rsp_s, 0);
    chk("rst_exec_rsp_z", rsp_z, 0);
    chk("rst_exec_rsp0_valid", rsp0_valid, 0);
    @(posedge clock); #1;
    resetn = 1'b1;
    last_m = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rst_exec_no_rsp0", rsp0_valid, 0);
      chk("rst_exec_rsp_s_hold", rsp_s, 0);
      @(posedge clock); #1;
    end
    set_op(0, 4'b0000, 32'd2, 32'd3);
    set_op(1, 4'b0001, 32'hFF00, 32'h0FF0);
    serve_one(0);
    serve_one(0);

    for (int it = 0; it < 80; it++) begin
      for (int id = 0; id < 2; id++) begin
        if (!pend[id] && ($urandom_range(0, 2) != 0)) begin
          if ($urandom_range(0, 1) == 1)
            set_op(id, 4'($urandom), $urandom_range(0, 40), $urandom);
          else
            set_op(id, 4'($urandom), $urandom, $urandom);
        end
      end
      if (!pend[0] && !pend[1]) begin
        drive_reqs();
        rsp0_ready = 1'($urandom);
        rsp1_ready = 1'($urandom);
        #1;
        chk("idle_req0_ready", req0_ready, 0);
        chk("idle_req1_ready", req1_ready, 0);
        chk("idle_rsp0_valid", rsp0_valid, 0);
        chk("idle_rsp1_valid", rsp1_valid, 0);
        @(posedge clock); #1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
      end else begin
        serve_one($urandom_range(0, 3));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
